mem_stage_ctrl: RTL and testbench
=================================

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15; max cycles BUSY waits for mem_ack before abort.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 MemRead  input  1  EX/MEM stage requests a data-memory load.
REQ-005 MemWrite  input  1  EX/MEM stage requests a data-memory store.
REQ-006 Addr  input  16  byte address from EX/MEM ALU result.
REQ-007 WData  input  16  store data from EX/MEM.
REQ-008 mem_req  output  1  registered request to data memory.
REQ-009 mem_wr  output  1  registered; 1 = write, 0 = read; valid while mem_req=1.
REQ-010 mem_addr  output  16  registered address; valid while mem_req=1.
REQ-011 mem_wdata  output  16  registered store data; valid while mem_req=1 and mem_wr=1.
REQ-012 mem_rdata  input  16  memory read data; sampled only when mem_ack=1.
REQ-013 mem_ack  input  1  memory completion; ignored unless mem_req=1.
REQ-014 stall  output  1  freezes PC, IF/ID, ID/EX, EX/MEM write enables.
REQ-015 MemData_out  output  16  load result; drives Prev_MemData of the MEM/WB register.
REQ-016 done  output  1  one-cycle pulse; MemData_out is valid this cycle.
REQ-017 err  output  1  sticky timeout flag.

Function
REQ-018 FSM states: IDLE, BUSY, DONE; encoding 2 bits.
REQ-019 IDLE: if MemRead|MemWrite, go to BUSY; latch Addr, WData, mem_wr = MemWrite; clear counter.
REQ-020 MemRead and MemWrite both high: store wins (mem_wr=1), no error.
REQ-021 mem_req = 1 exactly when state = BUSY; mem_addr, mem_wr, mem_wdata stay constant throughout BUSY.
REQ-022 BUSY with mem_ack=1: go to DONE; on read, capture mem_rdata into MemData_out.
REQ-023 BUSY without mem_ack: counter increments each cycle; at counter = TIMEOUT_CYCLES-1 without ack, go to DONE, set err, and load MemData_out with 16'h0000.
REQ-024 Ack and timeout in the same cycle: ack wins; err is not set.
REQ-025 On write completion, MemData_out holds its previous value.
REQ-026 DONE: done=1 for one cycle; next state is IDLE unconditionally; no new access is issued from DONE.
REQ-027 stall is combinational: 1 when (IDLE and (MemRead|MemWrite)) or BUSY; 0 in DONE.
REQ-028 Minimum latency: access seen in cycle 0, mem_req in cycle 1; ack in cycle 1 gives done in cycle 2. stall is high in cycles 0-1.
REQ-029 Back-to-back accesses: the next instruction appears in IDLE at cycle 3 and is handled as a new access.
REQ-030 err stays set until reset; it does not block later accesses.
REQ-031 Counter width is clog2(TIMEOUT_CYCLES)+1; it never wraps while in BUSY.

Reset
REQ-032 rst=0 forces the following immediately, independent of clk: state=IDLE, mem_req=0, mem_wr=0, mem_addr=0, mem_wdata=0, MemData_out=0, done=0, err=0, counter=0.
REQ-033 Reset asserted during BUSY drops mem_req the same instant; any late mem_ack after release is ignored.
REQ-034 The first access after reset release behaves as in REQ-028.

Structure
REQ-035 A shared package holds: the state enum (IDLE/BUSY/DONE), the 16-bit word-width constant, and the TIMEOUT_CYCLES default.
REQ-036 One sub-module, mem_timeout_ctr, provides the clearable saturating wait counter with a terminal-count output.
REQ-037 The 16-bit registers reuse the team's existing 16-bit DFF cell with write enable.

Verification
REQ-038 Load, ack on first BUSY cycle:
- Stimulus: MemRead=1, Addr=16'h0040; mem_ack=1, mem_rdata=16'hBEEF in cycle 1.
- Response: mem_req only in cycle 1; done and MemData_out=16'hBEEF in cycle 2; stall high in cycles 0-1.
REQ-039 Store, ack after 3 wait cycles:
- Stimulus: MemWrite=1, Addr=16'h0010, WData=16'h1234.
- Response: mem_wr=1, mem_addr=16'h0010, mem_wdata=16'h1234 stable for 4 cycles; MemData_out unchanged; done one cycle after ack.
REQ-040 Timeout:
- Stimulus: load with no ack, TIMEOUT_CYCLES=15.
- Response: mem_req high exactly 15 cycles; then done=1, err=1, MemData_out=16'h0000; err stays high through the next successful load.
REQ-041 Simultaneous requests:
- Stimulus: MemRead=MemWrite=1.
- Response: mem_wr=1.
REQ-042 Ack coincides with the terminal count:
- Response: err stays 0; data is captured.
REQ-043 Reset mid-BUSY:
- Stimulus: rst=0 during cycle 2 of a load, then mem_ack=1 after release.
- Response: all outputs 0 immediately; no done, no data capture; a subsequent load completes normally.

Source files
------------

// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory handshake controller.
package mem_stage_ctrl_pkg;

  localparam int WORD_W                 = 16;
  localparam int TIMEOUT_CYCLES_DEFAULT = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/dff16_en.sv
// 16-bit register cell with write enable and asynchronous active-low clear.
module dff16_en (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_en,
  input  logic [15:0] i_d,
  output logic [15:0] o_q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_q <= '0;
    end else if (i_en) begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/mem_timeout_ctr.sv
// Clearable saturating wait counter; o_tc flags the last permitted wait cycle.
module mem_timeout_ctr #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_tc
);

  localparam int            CW     = $clog2(LIMIT) + 1;
  localparam logic [CW-1:0] TC_VAL = CW'(LIMIT - 1);

  logic [CW-1:0] r_cnt;

  assign o_tc = (r_cnt == TC_VAL);

  // Holds at the terminal value so the count can never wrap during a long wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !o_tc) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: issues one data-memory access per load/store, stalls the
// pipeline while it is outstanding, and aborts with a sticky error on timeout.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [WORD_W-1:0] Addr,
  input  logic [WORD_W-1:0] WData,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic [WORD_W-1:0] MemData_out,
  output logic              done,
  output logic              err
);

  state_t            r_state;
  logic              r_mem_req;
  logic              r_mem_wr;
  logic              r_done;
  logic              r_err;

  logic              w_access;
  logic              w_busy;
  logic              w_accept;
  logic              w_tc;
  logic              w_ack;
  logic              w_timeout;
  logic              w_capture;
  logic [WORD_W-1:0] w_load_data;

  assign w_access    = MemRead | MemWrite;
  assign w_busy      = (r_state == BUSY);
  assign w_accept    = (r_state == IDLE) && w_access;
  assign w_ack       = w_busy && mem_ack;
  assign w_timeout   = w_busy && !mem_ack && w_tc;
  // Stores leave the load result untouched; an aborted access reads back as zero.
  assign w_capture   = (w_ack && !r_mem_wr) || w_timeout;
  assign w_load_data = w_timeout ? '0 : mem_rdata;

  assign stall       = w_accept || w_busy;
  assign mem_req     = r_mem_req;
  assign mem_wr      = r_mem_wr;
  assign done        = r_done;
  assign err         = r_err;

  mem_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .rst_n (rst),
    .i_clr (!w_busy),
    .i_inc (w_busy && !mem_ack),
    .o_tc  (w_tc)
  );

  dff16_en u_addr_reg (
    .clk   (clk),
    .rst_n (rst),
    .i_en  (w_accept),
    .i_d   (Addr),
    .o_q   (mem_addr)
  );

  dff16_en u_wdata_reg (
    .clk   (clk),
    .rst_n (rst),
    .i_en  (w_accept),
    .i_d   (WData),
    .o_q   (mem_wdata)
  );

  dff16_en u_rdata_reg (
    .clk   (clk),
    .rst_n (rst),
    .i_en  (w_capture),
    .i_d   (w_load_data),
    .o_q   (MemData_out)
  );

  // An ack arriving on the terminal-count cycle still counts as a clean completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_mem_req <= 1'b0;
      r_mem_wr  <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_access) begin
            r_state   <= BUSY;
            r_mem_req <= 1'b1;
            r_mem_wr  <= MemWrite;
          end
        end
        BUSY: begin
          if (mem_ack || w_tc) begin
            r_state   <= DONE;
            r_mem_req <= 1'b0;
            r_done    <= 1'b1;
            if (!mem_ack) begin
              r_err <= 1'b1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state   <= IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: vector table, scoreboard on done, and
// hand-written reset / back-to-back sequences.
module tb_mem_stage_ctrl;

  localparam int TOUT = 15;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          ackAfter;
    logic [15:0] rdata;
    logic        expWr;
    logic [15:0] expData;
    logic        expErr;
    int          expBusy;
  } vecT;

  typedef struct {
    logic [15:0] data;
    logic        err;
  } expT;

  logic        clk;
  logic        rst;
  logic        MemRead;
  logic        MemWrite;
  logic [15:0] Addr;
  logic [15:0] WData;
  logic        mem_req;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        stall;
  logic [15:0] MemData_out;
  logic        done;
  logic        err;

  int  checks = 0;
  int  errors = 0;
  expT sbQueue[$];
  expT monExp;
  vecT vecs[8];

  mem_stage_ctrl #(
    .TIMEOUT_CYCLES (TOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .Addr        (Addr),
    .WData       (WData),
    .mem_req     (mem_req),
    .mem_wr      (mem_wr),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .stall       (stall),
    .MemData_out (MemData_out),
    .done        (done),
    .err         (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest pending access.
  always @(negedge clk) begin
    if (rst && done) begin
      if (sbQueue.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: got done=1 expected no pending access");
      end else begin
        monExp = sbQueue.pop_front();
        checkOutput("sb_data", {16'h0, MemData_out}, {16'h0, monExp.data});
        checkOutput("sb_err", {31'h0, err}, {31'h0, monExp.err});
      end
    end
  end

  task automatic applyStimulus(input vecT v);
    expT e;
    int  busyCycles;
    MemRead  = v.rd;
    MemWrite = v.wr;
    Addr     = v.addr;
    WData    = v.wdata;
    #1;
    checkOutput("stall_c0", {31'h0, stall}, 32'd1);
    checkOutput("req_c0", {31'h0, mem_req}, 32'd0);
    e.data = v.expData;
    e.err  = v.expErr;
    sbQueue.push_back(e);
    @(negedge clk);
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    Addr       = 16'hFFFF;
    WData      = 16'hFFFF;
    busyCycles = 0;
    while (mem_req && busyCycles < 40) begin
      checkOutput("busy_wr", {31'h0, mem_wr}, {31'h0, v.expWr});
      checkOutput("busy_addr", {16'h0, mem_addr}, {16'h0, v.addr});
      if (v.expWr) checkOutput("busy_wdata", {16'h0, mem_wdata}, {16'h0, v.wdata});
      checkOutput("busy_stall", {31'h0, stall}, 32'd1);
      if (busyCycles == v.ackAfter) begin
        mem_ack   = 1'b1;
        mem_rdata = v.rdata;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 16'h7777;
      end
      @(negedge clk);
      busyCycles++;
    end
    mem_ack = 1'b0;
    checkOutput("busy_len", busyCycles, v.expBusy);
    checkOutput("done_hi", {31'h0, done}, 32'd1);
    checkOutput("done_stall", {31'h0, stall}, 32'd0);
    @(negedge clk);
    checkOutput("done_lo", {31'h0, done}, 32'd0);
    checkOutput("idle_req", {31'h0, mem_req}, 32'd0);
  endtask

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    //          rd    wr    addr      wdata     ack  rdata     expWr expData   expErr busy
    vecs[0] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 0,   16'hBEEF, 1'b0, 16'hBEEF, 1'b0,  1};
    vecs[1] = '{1'b0, 1'b1, 16'h0010, 16'h1234, 3,   16'h9999, 1'b1, 16'hBEEF, 1'b0,  4};
    vecs[2] = '{1'b1, 1'b1, 16'h0020, 16'h5555, 0,   16'h9999, 1'b1, 16'hBEEF, 1'b0,  1};
    vecs[3] = '{1'b1, 1'b0, 16'h0030, 16'h0000, 14,  16'hCAFE, 1'b0, 16'hCAFE, 1'b0,  15};
    vecs[4] = '{1'b1, 1'b0, 16'h0044, 16'h0000, -1,  16'h0000, 1'b0, 16'h0000, 1'b1,  15};
    vecs[5] = '{1'b1, 1'b0, 16'h0050, 16'h0000, 2,   16'h1357, 1'b0, 16'h1357, 1'b1,  3};
    vecs[6] = '{1'b0, 1'b1, 16'h0060, 16'hA5A5, 0,   16'h9999, 1'b1, 16'h1357, 1'b1,  1};
    vecs[7] = '{1'b1, 1'b0, 16'h0080, 16'h0000, 1,   16'h2468, 1'b0, 16'h2468, 1'b0,  2};

    rst       = 1'b1;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    Addr      = 16'h0;
    WData     = 16'h0;
    mem_rdata = 16'h0;
    mem_ack   = 1'b0;
    #2 rst = 1'b0;

    @(negedge clk);
    checkOutput("rst_req", {31'h0, mem_req}, 32'd0);
    checkOutput("rst_wr", {31'h0, mem_wr}, 32'd0);
    checkOutput("rst_addr", {16'h0, mem_addr}, 32'd0);
    checkOutput("rst_data", {16'h0, MemData_out}, 32'd0);
    checkOutput("rst_done_err", {30'h0, done, err}, 32'd0);
    checkOutput("rst_stall", {31'h0, stall}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      $display("[TB] vector %0d", i);
      applyStimulus(vecs[i]);
    end
    checkOutput("err_sticky", {31'h0, err}, 32'd1);

    // Reset in the second BUSY cycle: everything clears at once, late ack ignored.
    MemRead = 1'b1;
    Addr    = 16'h0070;
    @(negedge clk);
    MemRead = 1'b0;
    @(negedge clk);
    checkOutput("pre_rst_req", {31'h0, mem_req}, 32'd1);
    #2 rst = 1'b0;
    #1;
    checkOutput("midrst_req", {31'h0, mem_req}, 32'd0);
    checkOutput("midrst_addr", {16'h0, mem_addr}, 32'd0);
    checkOutput("midrst_data", {16'h0, MemData_out}, 32'd0);
    checkOutput("midrst_err", {31'h0, err}, 32'd0);
    checkOutput("midrst_done", {31'h0, done}, 32'd0);
    @(negedge clk);
    rst       = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 16'hDEAD;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("late_ack_req", {31'h0, mem_req}, 32'd0);
      checkOutput("late_ack_done", {31'h0, done}, 32'd0);
      checkOutput("late_ack_data", {16'h0, MemData_out}, 32'd0);
    end
    mem_ack = 1'b0;
    applyStimulus(vecs[7]);

    // Back-to-back: MemRead held high; the second access starts only from IDLE.
    MemRead = 1'b1;
    Addr    = 16'h0090;
    sbQueue.push_back('{16'h1111, 1'b0});
    @(negedge clk);
    checkOutput("b2b_req1", {31'h0, mem_req}, 32'd1);
    mem_ack   = 1'b1;
    mem_rdata = 16'h1111;
    @(negedge clk);
    mem_ack = 1'b0;
    checkOutput("b2b_done1", {31'h0, done}, 32'd1);
    checkOutput("b2b_done_stall", {31'h0, stall}, 32'd0);
    checkOutput("b2b_done_req", {31'h0, mem_req}, 32'd0);
    Addr = 16'h00A0;
    sbQueue.push_back('{16'h2222, 1'b0});
    @(negedge clk);
    checkOutput("b2b_idle_stall", {31'h0, stall}, 32'd1);
    checkOutput("b2b_idle_req", {31'h0, mem_req}, 32'd0);
    @(negedge clk);
    checkOutput("b2b_req2", {31'h0, mem_req}, 32'd1);
    checkOutput("b2b_addr2", {16'h0, mem_addr}, 32'h00A0);
    MemRead   = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 16'h2222;
    @(negedge clk);
    mem_ack = 1'b0;
    checkOutput("b2b_done2", {31'h0, done}, 32'd1);
    @(negedge clk);
    @(negedge clk);

    checkOutput("sb_drained", sbQueue.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
